sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
Parametrised synchronous controller for an external asynchronous SRAM, such as the 256Kx16 part on the board. It turns a single-beat valid/ready request port into correctly sequenced CS/WE/OE/byte-lane/address/data pin activity. Wait states and read-to-write bus turnaround are configurable. It sits between on-chip masters (`chip` top level) and the SRAM pins.

Parameters:
- ADDR_W, 18, SRAM word-address width.
- DATA_W, 16, SRAM data width; must be a multiple of 8. LANES = DATA_W/8.
- WAIT_STATES, 1, extra access cycles beyond the first; legal range 0..15.
- TURNAROUND, 1, idle cycles after every read before the next access; legal range 0..7.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- greset  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_be  in  LANES  byte enables, active-high.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  one-cycle pulse when read data is valid.
- resp_rdata  out  DATA_W  read data.
- RAMCS  out  1  chip select, active-low.
- RAMWE  out  1  write enable, active-low.
- RAMOE  out  1  output enable, active-low.
- RAMBE  out  LANES  byte-lane enables, active-low; bit0 = LB, bit1 = UB.
- ADR  out  ADDR_W  SRAM address.
- DAT  inout  DATA_W  SRAM data; driven only during writes, high-Z otherwise.

Behaviour:
- All pin outputs and resp_* are registered. No combinational path from req_* to pins.
- Reset (greset=0 at a rising edge):
  - FSM returns to IDLE.
  - RAMCS, RAMWE, RAMOE = 1; RAMBE = all 1; ADR = 0; DAT = high-Z.
  - resp_valid = 0; resp_rdata = 0; req_ready = 0 while greset=0.
  - Reset takes effect mid-access with no completion and no resp_valid.
- FSM states: IDLE, ACCESS, HOLD, TURN. Counter cnt is 4 bits.
- IDLE:
  - req_ready = 1; pins inactive; DAT high-Z.
  - Accept on req_valid & req_ready. On accept, latch we/addr/be/wdata, load cnt = WAIT_STATES, go to ACCESS.
  - req_* are ignored when req_ready = 0.
- ACCESS (WAIT_STATES+1 cycles):
  - RAMCS = 0; ADR = latched address; RAMBE[i] = ~be[i].
  - Write: RAMWE = 0, RAMOE = 1, DAT driven with wdata.
  - Read: RAMOE = 0, RAMWE = 1, DAT high-Z.
  - cnt decrements each cycle. At cnt = 0, leave the state:
    - Write → HOLD.
    - Read → sample DAT into resp_rdata (lanes with be = 0 forced to 0); resp_valid = 1 for the next cycle only. Then go to TURN if TURNAROUND > 0, else IDLE.
- HOLD (1 cycle, writes only):
  - RAMWE = 1; RAMCS = 0; ADR and DAT held. This gives data/address hold after the WE rising edge.
  - Then → IDLE.
- TURN (TURNAROUND cycles):
  - All pins inactive; DAT high-Z; req_ready = 0. Then → IDLE.
- Timing (accept in cycle N):
  - Read: ACCESS N+1..N+1+WAIT_STATES; resp_valid in cycle N+2+WAIT_STATES; IDLE at N+2+WAIT_STATES+TURNAROUND.
  - Write: ACCESS N+1..N+1+WAIT_STATES; HOLD N+2+WAIT_STATES; IDLE at N+3+WAIT_STATES.
- Throughput: one request per access cycle. req_ready is low from the accept cycle+1 until re-entry to IDLE; there is no pipelining.
- req_be = 0:
  - The access still runs with RAMCS = 0 and all lanes disabled.
  - A read still pulses resp_valid, with resp_rdata = 0.
- Bus safety:
  - DAT is never driven while RAMOE = 0.
  - RAMWE and RAMOE are never both low.
  - ADR is stable for every cycle in which RAMCS = 0.

Test Plan:
- Reset then idle (greset=0 for 10 cycles, then 1): during reset, all pins inactive and req_ready = 0; req_ready = 1 in the first cycle after release; DAT high-Z throughout.
- Read, WAIT_STATES=1, TURNAROUND=1: read 0x00A5C with be=2'b11; SRAM model returns ADR[15:0]. Expect RAMOE low for exactly 2 cycles and resp_valid in cycle N+3 with resp_rdata = 16'h0A5C. req_ready returns at N+4.
- Write then read back, with a storage SRAM model: write 0x12345 ← 16'hBEEF with be=2'b11. Expect RAMWE low for 2 cycles, then 1 HOLD cycle with DAT still 16'hBEEF. Then write be=2'b01 ← 16'h0011; a read returns 16'hBE11.
- Read with be=2'b10 at address 0x000FF: expect RAMBE = 2'b01 and resp_rdata = 16'h0000 (lane 1 of 0x00FF is 0x00, lane 0 is masked).
- Back-to-back read→write with req_valid held high: the write's RAMWE falls no earlier than 1 TURN cycle after RAMOE rises. A bus checker flags any DAT drive while RAMOE = 0, and any overlap of RAMWE and RAMOE low.
- Reset mid-read (greset=0 in the second ACCESS cycle): the next cycle shows pins inactive and resp_valid never asserts. A following read of 0x00003 completes normally with resp_rdata = 16'h0003.

Source files
------------

// File: rtl/sram_ctrl.sv
// Synchronous controller for an external asynchronous SRAM: one valid/ready request
// becomes a timed CS/WE/OE/byte-lane/address/data sequence with wait states and read turnaround.
module sram_ctrl #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned TURNAROUND  = 1
) (
  input  logic                  clk,
  input  logic                  greset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W/8-1:0]   req_be,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  RAMCS,
  output logic                  RAMWE,
  output logic                  RAMOE,
  output logic [DATA_W/8-1:0]   RAMBE,
  output logic [ADDR_W-1:0]     ADR,
  inout  wire  [DATA_W-1:0]     DAT
);

  localparam int unsigned LANES = DATA_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_HOLD, S_TURN} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [LANES-1:0]    be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                ramcs_q, ramcs_d;
  logic                ramwe_q, ramwe_d;
  logic                ramoe_q, ramoe_d;
  logic [LANES-1:0]    rambe_q, rambe_d;
  logic                dat_oe_q, dat_oe_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic [DATA_W-1:0]   lane_mask;
  logic                pins_on;

  // Next-state, request latching and next pin values derived from the state being entered
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    adr_d        = adr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    lane_mask    = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_mask[i*8 +: 8] = {8{be_q[i]}};
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          we_d    = req_we;
          adr_d   = req_addr;
          be_d    = req_be;
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_STATES);
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          if (we_q) begin
            state_d = S_HOLD;
          end else begin
            resp_valid_d = 1'b1;
            resp_rdata_d = DAT & lane_mask;
            if (TURNAROUND > 0) begin
              state_d = S_TURN;
              cnt_d   = 4'(TURNAROUND - 1);
            end else begin
              state_d = S_IDLE;
            end
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: state_d = S_IDLE;
      S_TURN: begin
        if (cnt_q == 4'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // HOLD keeps CS, lanes, address and data but releases WE
    pins_on     = (state_d == S_ACCESS) || (state_d == S_HOLD);
    ramcs_d     = !pins_on;
    ramwe_d     = !((state_d == S_ACCESS) && we_d);
    ramoe_d     = !((state_d == S_ACCESS) && !we_d);
    rambe_d     = pins_on ? ~be_d : '1;
    dat_oe_d    = pins_on && we_d;
    req_ready_d = (state_d == S_IDLE);
  end

  // State and pin registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!greset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      ramcs_q      <= 1'b1;
      ramwe_q      <= 1'b1;
      ramoe_q      <= 1'b1;
      rambe_q      <= '1;
      dat_oe_q     <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      ramcs_q      <= ramcs_d;
      ramwe_q      <= ramwe_d;
      ramoe_q      <= ramoe_d;
      rambe_q      <= rambe_d;
      dat_oe_q     <= dat_oe_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign RAMCS      = ramcs_q;
  assign RAMWE      = ramwe_q;
  assign RAMOE      = ramoe_q;
  assign RAMBE      = rambe_q;
  assign ADR        = adr_q;
  assign DAT        = dat_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized self-checking bench for sram_ctrl against a storage SRAM model and a
// transaction-level timeline/reference-memory model.
module tb_sram_ctrl;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
  localparam int unsigned LN = 2;
  localparam int unsigned WS = 1;
  localparam int unsigned TA = 1;

  logic          clk = 1'b0;
  logic          greset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [LN-1:0] req_be = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          ramcs, ramwe, ramoe;
  logic [LN-1:0] rambe;
  logic [AW-1:0] adr;
  wire  [DW-1:0] dat;

  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem  [0:(1<<AW)-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS), .TURNAROUND(TA)) dut (
    .clk(clk), .greset(greset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .RAMCS(ramcs), .RAMWE(ramwe), .RAMOE(ramoe), .RAMBE(rambe),
    .ADR(adr), .DAT(dat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Asynchronous SRAM: drives data while selected and output-enabled, stores lanes under WE
  assign dat = (!ramcs && !ramoe && ramwe) ? sram_mem[adr] : {DW{1'bz}};
  always @(posedge clk) begin
    if (greset && !ramcs && !ramwe) begin
      for (int l = 0; l < LN; l++)
        if (!rambe[l]) sram_mem[adr][l*8 +: 8] <= dat[l*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bus checker: no WE/OE overlap, stable address under CS, read-to-write gap
  logic prev_cs = 1'b1, prev_oe = 1'b1, prev_we = 1'b1, seen_oe_rise = 1'b0;
  logic [AW-1:0] prev_adr = '0;
  int oe_rise_cyc = 0;
  always @(negedge clk) begin
    check("we_oe_overlap", 32'(!ramwe && !ramoe), 32'd0);
    if (!ramcs && !prev_cs) check("adr_stable", 32'(adr), 32'(prev_adr));
    if (ramoe && !prev_oe) begin
      oe_rise_cyc  = cyc;
      seen_oe_rise = 1'b1;
    end
    if (!ramwe && prev_we && seen_oe_rise)
      check("rd_wr_gap_ok", 32'((cyc - oe_rise_cyc) >= int'(TA + 1)), 32'd1);
    prev_cs  = ramcs;
    prev_oe  = ramoe;
    prev_we  = ramwe;
    prev_adr = adr;
  end

  function automatic logic [DW-1:0] lane_mask(input logic [LN-1:0] be);
    logic [DW-1:0] m = '0;
    for (int l = 0; l < LN; l++) if (be[l]) m[l*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [6:0] pins_now();
    return {ramcs, ramwe, ramoe, rambe, req_ready, resp_valid};
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) return;
    end
    check("ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one request and check every cycle of its timeline from the accept edge onward
  task automatic run_req(input logic we, input logic [AW-1:0] a, input logic [LN-1:0] be,
                         input logic [DW-1:0] wd);
    logic [DW-1:0] exp_rd;
    int total;
    wait_ready();
    req_we = we; req_addr = a; req_be = be; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_rd = ref_mem[a] & lane_mask(be);
    if (we) ref_mem[a] = (ref_mem[a] & ~lane_mask(be)) | (wd & lane_mask(be));
    total = we ? int'(WS + 3) : int'(WS + 2 + TA);
    for (int k = 1; k <= total; k++) begin
      logic acc, hold, active;
      logic [6:0] exp_pins;
      @(negedge clk);
      acc    = (k <= int'(WS + 1));
      hold   = we && (k == int'(WS + 2));
      active = acc || hold;
      exp_pins = {!active, !(acc && we), !(acc && !we), active ? ~be : {LN{1'b1}},
                  (k >= (we ? int'(WS + 3) : int'(WS + 2 + TA))), (!we && k == int'(WS + 2))};
      check(we ? "wr_pins" : "rd_pins", 32'(pins_now()), 32'(exp_pins));
      if (active) check("adr", 32'(adr), 32'(a));
      if (we && active) check("wr_dat", 32'(dat), 32'(wd));
      if (!we && k == int'(WS + 2)) check("rd_data", 32'(resp_rdata), 32'(exp_rd));
    end
  endtask

  logic [AW-1:0] pool [8];

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      sram_mem[i] = DW'(i);
      ref_mem[i]  = DW'(i);
    end
    for (int i = 0; i < 8; i++) pool[i] = AW'(32'h20000 + 32'(i) * 32'h111);

    // Reset: pins inactive, not ready
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        check("rst_pins", 32'(pins_now()), 32'({1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0}));
        check("rst_adr", 32'(adr), 32'd0);
        check("rst_rdata", 32'(resp_rdata), 32'd0);
      end
    end
    greset = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 32'(req_ready), 32'd1);

    // Directed accesses
    run_req(1'b0, 18'h00A5C, 2'b11, 16'h0000);
    run_req(1'b1, 18'h12345, 2'b11, 16'hBEEF);
    run_req(1'b1, 18'h12345, 2'b01, 16'h0011);
    run_req(1'b0, 18'h12345, 2'b11, 16'h0000);
    check("rmw_value", 32'(resp_rdata), 32'h0000BE11);
    run_req(1'b0, 18'h000FF, 2'b10, 16'h0000);
    run_req(1'b0, 18'h00777, 2'b00, 16'h0000);

    // Back-to-back read then write with req_valid held high
    wait_ready();
    req_we = 1'b0; req_addr = 18'h00500; req_be = 2'b11; req_valid = 1'b1;
    @(posedge clk); #1;
    req_we = 1'b1; req_addr = 18'h00600; req_wdata = 16'hCAFE; req_be = 2'b11;
    ref_mem[18'h00600] = 16'hCAFE;
    wait_ready();
    @(posedge clk); #1;
    req_valid = 1'b0;
    run_req(1'b0, 18'h00600, 2'b11, 16'h0000);

    // Reset during the second access cycle of a read
    wait_ready();
    req_we = 1'b0; req_addr = 18'h00040; req_be = 2'b11; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    greset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_pins", 32'(pins_now()), 32'({1'b1, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0}));
    greset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_resp", 32'(resp_valid), 32'd0);
    end
    run_req(1'b0, 18'h00003, 2'b11, 16'h0000);
    check("post_rst_read", 32'(resp_rdata), 32'h00000003);

    // Randomized mix against the reference memory
    for (int t = 0; t < 60; t++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 1) == 1) ? pool[$urandom_range(0, 7)]
                                      : AW'($urandom_range(256, (1 << AW) - 1));
      run_req(1'($urandom_range(0, 1)), a, LN'($urandom_range(0, 3)), DW'($urandom));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
